// File: rtl/mdll_divider_counter.sv
// MDLL feedback divider: M-frame position counter, N divider, and injection-alignment lock detector.
// All outputs come straight from flops; reset is synchronous active-low.
module mdll_divider_counter #(
  parameter int unsigned NW       = 4,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [1:0]    M,
  input  logic [NW-1:0] N,
  input  logic [1:0]    Sel,
  output logic [1:0]    M_counter,
  output logic          DIV_M,
  output logic          DIV_N,
  output logic          lock
);

  localparam logic [2:0] LOCK_MAX = 3'(LOCK_CNT);

  logic [1:0]    m_eff;
  logic [NW-1:0] n_eff;
  logic [NW-1:0] n_half;
  logic [NW-1:0] n_cnt;
  logic [NW-1:0] n_cnt_d;
  logic [1:0]    m_cnt_d;
  logic [2:0]    lock_cnt;
  logic [2:0]    lock_cnt_d;
  logic          inj;

  // Next-state computation; the injection cycle counts as frame position 1.
  always_comb begin
    m_eff      = (M == 2'd0) ? 2'd1 : M;
    n_eff      = (N == '0) ? NW'(1) : N;
    n_half     = n_eff >> 1;
    inj        = (Sel == 2'b00);
    m_cnt_d    = M_counter;
    n_cnt_d    = n_cnt;
    lock_cnt_d = lock_cnt;

    if (inj) begin
      m_cnt_d = (m_eff == 2'd1) ? 2'd1 : 2'd2;
    end else if (M_counter >= m_eff) begin
      m_cnt_d = 2'd1;
    end else begin
      m_cnt_d = M_counter + 2'd1;
    end

    if (n_cnt >= n_eff - NW'(1)) begin
      n_cnt_d = '0;
    end else begin
      n_cnt_d = n_cnt + NW'(1);
    end

    if (inj) begin
      if (M_counter != 2'd1) begin
        lock_cnt_d = 3'd0;
      end else if (lock_cnt < LOCK_MAX) begin
        lock_cnt_d = lock_cnt + 3'd1;
      end
    end
  end

  // State and output registers; en low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      M_counter <= 2'd1;
      DIV_M     <= 1'b1;
      n_cnt     <= '0;
      DIV_N     <= (n_eff == NW'(1));
      lock_cnt  <= 3'd0;
      lock      <= 1'b0;
    end else if (en) begin
      M_counter <= m_cnt_d;
      DIV_M     <= (m_cnt_d == 2'd1);
      n_cnt     <= n_cnt_d;
      DIV_N     <= (n_cnt_d >= n_half);
      lock_cnt  <= lock_cnt_d;
      lock      <= (lock_cnt_d == LOCK_MAX);
    end
  end

endmodule

// File: tb/tb_mdll_divider_counter.sv
// Bench for mdll_divider_counter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an arithmetic reference model.
module tb_mdll_divider_counter;

  localparam int NW   = 4;
  localparam int LOCK = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    M;
  logic [NW-1:0] N;
  logic [1:0]    Sel;
  logic [1:0]    M_counter;
  logic          DIV_M;
  logic          DIV_N;
  logic          lock;

  int vectors = 0;
  int errors  = 0;

  mdll_divider_counter #(.NW(NW), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .M(M), .N(N), .Sel(Sel),
    .M_counter(M_counter), .DIV_M(DIV_M), .DIV_N(DIV_N), .lock(lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position, divider phase and aligned-injection count as integers.
  int m_pos = 1, n_pos = 0, lk = 0;
  bit e_div_n = 1'b0;
  bit valid   = 1'b0;

  always @(posedge clk) begin
    int me, ne;
    me = (M == 0) ? 1 : int'(M);
    ne = (N == 0) ? 1 : int'(N);
    if (!rst_n) begin
      m_pos = 1; n_pos = 0; lk = 0; valid = 1'b1;
      e_div_n = (n_pos >= ne / 2);
    end else if (en && valid) begin
      if (Sel == 2'b00) begin
        lk    = (m_pos == 1) ? ((lk < LOCK) ? lk + 1 : lk) : 0;
        m_pos = (me == 1) ? 1 : 2;
      end else begin
        m_pos = (m_pos > me) ? 1 : (m_pos % me) + 1;
      end
      n_pos   = (n_pos >= ne) ? 0 : (n_pos + 1) % ne;
      e_div_n = (n_pos >= ne / 2);
    end
  end

  always @(posedge clk) begin
    #2;
    if (valid) begin
      check("model_M_counter", 32'(M_counter), 32'(m_pos));
      check("model_DIV_M", 32'(DIV_M), 32'(m_pos == 1));
      check("model_DIV_N", 32'(DIV_N), 32'(e_div_n));
      check("model_lock", 32'(lock), 32'(lk == LOCK));
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [NW-1:0] n);
    M = m; N = n; Sel = 2'b01; en = 1'b1; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Expects M==2 and M_counter==1; leaves M_counter==2 right after the LOCK-th aligned pulse.
  task automatic lock_up();
    for (int i = 0; i < LOCK; i++) begin
      Sel = 2'b00;
      step();
      check("lock_pulse_M_counter", 32'(M_counter), 32'd2);
      check("lock_pulse_lock", 32'(lock), 32'(i == LOCK - 1));
      Sel = 2'b01;
      if (i != LOCK - 1) step();
    end
  endtask

  initial begin
    int div5_pat[10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
    int mseq[5]      = '{2, 3, 1, 2, 3};
    int nrecfg[4]    = '{0, 1, 1, 0};

    rst_n = 1'b0; en = 1'b1; M = 2'd3; N = NW'(4); Sel = 2'b01;

    // Reset with N=4, M=3, then frame sequence.
    repeat (3) step();
    check("rst_M_counter", 32'(M_counter), 32'd1);
    check("rst_DIV_M", 32'(DIV_M), 32'd1);
    check("rst_DIV_N", 32'(DIV_N), 32'd0);
    check("rst_lock", 32'(lock), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("seq_M_counter", 32'(M_counter), 32'(mseq[i]));
      check("seq_DIV_M", 32'(DIV_M), 32'(mseq[i] == 1));
    end

    // Divide by 5, then N=0 behaves as divide by 1.
    do_reset(2'd3, NW'(5));
    check("div5_reset_DIV_N", 32'(DIV_N), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("div5_DIV_N", 32'(DIV_N), 32'(div5_pat[i]));
    end
    N = '0;
    repeat (3) begin
      step();
      check("div1_DIV_N", 32'(DIV_N), 32'd1);
    end

    // Lock acquisition and loss on a misaligned injection.
    do_reset(2'd2, NW'(5));
    lock_up();
    Sel = 2'b00;
    step();
    check("misalign_M_counter", 32'(M_counter), 32'd2);
    check("misalign_lock", 32'(lock), 32'd0);
    Sel = 2'b01;

    // M reconfigured from 3 to 1 while at position 3.
    do_reset(2'd3, NW'(5));
    step(); step();
    check("recfg_M_at3", 32'(M_counter), 32'd3);
    M = 2'd1;
    repeat (4) begin
      step();
      check("recfg_M1_M_counter", 32'(M_counter), 32'd1);
      check("recfg_M1_DIV_M", 32'(DIV_M), 32'd1);
    end

    // N reconfigured from 8 to 3 while n_cnt is 6.
    do_reset(2'd3, NW'(8));
    repeat (6) step();
    check("recfg_N8_DIV_N", 32'(DIV_N), 32'd1);
    N = NW'(3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("recfg_N3_DIV_N", 32'(DIV_N), 32'(nrecfg[i]));
    end

    // Enable low freezes state despite Sel==00 activity.
    do_reset(2'd3, NW'(5));
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Sel = (i % 2 == 0) ? 2'b00 : 2'b10;
      step();
      check("hold_M_counter", 32'(M_counter), 32'd3);
      check("hold_DIV_M", 32'(DIV_M), 32'd0);
      check("hold_DIV_N", 32'(DIV_N), 32'd1);
      check("hold_lock", 32'(lock), 32'd0);
    end
    en = 1'b1; Sel = 2'b01;
    step();
    check("resume_M_counter", 32'(M_counter), 32'd1);
    check("resume_DIV_N", 32'(DIV_N), 32'd1);

    // Reset mid-run while locked at position 2.
    do_reset(2'd2, NW'(5));
    lock_up();
    rst_n = 1'b0;
    step();
    check("midrst_M_counter", 32'(M_counter), 32'd1);
    check("midrst_lock", 32'(lock), 32'd0);
    check("midrst_DIV_N", 32'(DIV_N), 32'd0);
    rst_n = 1'b1;

    // Randomized traffic, biased toward aligned injections so lock is exercised.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 9) != 0);
      Sel   = 2'($urandom_range(0, 3));
      if (m_pos == 1 && $urandom_range(0, 2) != 0) Sel = 2'b00;
      else if (Sel == 2'b00 && $urandom_range(0, 3) != 0) Sel = 2'b11;
      if ($urandom_range(0, 49) == 0) M = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) N = NW'($urandom_range(0, (1 << NW) - 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
